// File: rtl/cby_cfg_shadow_param_if.sv
// Bus bundle for the parametrised Y-channel connection block: channel tracks,
// configuration chain controls, pin drives and config status/debug.
interface cby_cfg_shadow_param_if #(
    parameter int CHAN_WIDTH = 11,
    parameter int NUM_IPIN   = 8
);
    logic [CHAN_WIDTH-1:0] chany_bottom_in;
    logic [CHAN_WIDTH-1:0] chany_top_in;
    logic [CHAN_WIDTH-1:0] chany_top_out;
    logic [CHAN_WIDTH-1:0] chany_bottom_out;
    logic                  ccff_head;
    logic                  ccff_en;
    logic                  cfg_load;
    logic [NUM_IPIN-1:0]   ipin_out;
    logic                  ccff_tail;
    logic                  cfg_valid;
    logic                  cfg_error;
    // dbg_state = {cfg_error, cfg_valid}; dbg_cnt = bits shifted since last load
    logic [1:0]            dbg_state;
    logic [15:0]           dbg_cnt;

    modport master (
        output chany_bottom_in, chany_top_in, ccff_head, ccff_en, cfg_load,
        input  chany_top_out, chany_bottom_out, ipin_out, ccff_tail,
               cfg_valid, cfg_error, dbg_state, dbg_cnt
    );

    modport slave (
        input  chany_bottom_in, chany_top_in, ccff_head, ccff_en, cfg_load,
        output chany_top_out, chany_bottom_out, ipin_out, ccff_tail,
               cfg_valid, cfg_error, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/cby_cfg_shadow_param.sv
// Parametrised Y-channel connection block: straight-through tracks plus one-hot
// input-pin muxes fed from an active config copied from a shifted shadow chain.
module cby_cfg_shadow_param #(
    parameter int CHAN_WIDTH  = 11,
    parameter int NUM_IPIN    = 8,
    parameter int TAPS        = 3,
    parameter int IDXW        = 4,
    parameter logic [NUM_IPIN*TAPS*IDXW-1:0] TAP_TABLE = {
        4'd7, 4'd6, 4'd1,    // pin7
        4'd6, 4'd5, 4'd0,    // pin6
        4'd10, 4'd5, 4'd4,   // pin5
        4'd9, 4'd4, 4'd3,    // pin4
        4'd8, 4'd3, 4'd2,    // pin3
        4'd7, 4'd2, 4'd1,    // pin2
        4'd6, 4'd1, 4'd0,    // pin1
        4'd10, 4'd5, 4'd0    // pin0
    },
    parameter int EXPECT_BITS = 0
) (
    input logic                  prog_clk,
    input logic                  pReset,
    cby_cfg_shadow_param_if.slave bus
);
    localparam int MUX_SIZE = 2 * TAPS;
    localparam int TOTAL    = NUM_IPIN * MUX_SIZE;

    localparam int           VALID_BIT = 0;
    localparam int           ERR_BIT   = 1;
    localparam logic [1:0]   ST_UNCFG  = 2'b00;

    // Control strobes: ccff_en and cfg_load are single-cycle qualifiers sampled on
    // every prog_clk edge; there is no ready/backpressure, each asserted cycle acts.
    logic [TOTAL-1:0]    sr;
    logic [TOTAL-1:0]    ar;
    logic [15:0]         cnt;
    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [NUM_IPIN-1:0] pin_ok;
    logic [NUM_IPIN-1:0] ipin;
    logic                words_ok;
    logic                count_ok;
    logic                load_ok;

    assign bus.chany_top_out    = bus.chany_bottom_in;
    assign bus.chany_bottom_out = bus.chany_top_in;
    assign bus.ccff_tail        = sr[TOTAL-1];
    assign bus.ipin_out         = ipin;
    assign bus.dbg_cnt          = cnt;

    for (genvar i = 0; i < NUM_IPIN; i++) begin : g_pin
        logic [MUX_SIZE-1:0] sel_in;
        logic [MUX_SIZE-1:0] word;

        for (genvar j = 0; j < TAPS; j++) begin : g_tap
            localparam int IDX = int'(TAP_TABLE[(i*TAPS+j)*IDXW +: IDXW]);
            assign sel_in[2*j]   = bus.chany_bottom_in[IDX];
            assign sel_in[2*j+1] = bus.chany_top_in[IDX];
        end

        assign word      = sr[i*MUX_SIZE +: MUX_SIZE];
        // Clearing the lowest set bit leaves zero only for a zero-or-one-hot word.
        assign pin_ok[i] = ((word & (word - MUX_SIZE'(1))) == '0);
        assign ipin[i]   = |(ar[i*MUX_SIZE +: MUX_SIZE] & sel_in);
    end

    assign words_ok = &pin_ok;
    assign count_ok = (EXPECT_BITS == 0) || (cnt == 16'(EXPECT_BITS));
    assign load_ok  = bus.cfg_load && words_ok && count_ok;

    // Load decisions use the pre-shift shadow, so a same-cycle shift is harmless.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            sr  <= '0;
            ar  <= '0;
            cnt <= '0;
        end else begin
            if (bus.ccff_en) begin
                sr <= {sr[TOTAL-2:0], bus.ccff_head};
            end
            if (load_ok) begin
                ar <= sr;
            end
            if (bus.cfg_load) begin
                cnt <= bus.ccff_en ? 16'd1 : 16'd0;
            end else if (bus.ccff_en && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q <= ST_UNCFG;
        end else begin
            state_q <= state_d;
        end
    end

    // Error is sticky until reset; a legal load still marks the config valid.
    always_comb begin
        state_d = state_q;
        if (bus.cfg_load) begin
            if (load_ok) begin
                state_d[VALID_BIT] = 1'b1;
            end else begin
                state_d[ERR_BIT] = 1'b1;
            end
        end
    end

    always_comb begin
        bus.cfg_valid = state_q[VALID_BIT];
        bus.cfg_error = state_q[ERR_BIT];
        bus.dbg_state = state_q;
    end
endmodule

// File: tb/tb_cby_cfg_shadow_param.sv
// Bench for cby_cfg_shadow_param: table vectors, hand-written corner sequences and
// randomized traffic checked against a queue/array model of the config rules.
module tb_cby_cfg_shadow_param;
    localparam int CW    = 11;
    localparam int NP    = 8;
    localparam int TAPS  = 3;
    localparam int MS    = 2 * TAPS;
    localparam int TOTAL = NP * MS;

    typedef struct {
        logic [TOTAL-1:0] word;
        logic [CW-1:0]    bot;
        logic [CW-1:0]    top;
        logic [NP-1:0]    ipin;
        logic             valid;
        logic             err;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cby_cfg_shadow_param_if #(.CHAN_WIDTH(CW), .NUM_IPIN(NP)) bus0 ();
    cby_cfg_shadow_param_if #(.CHAN_WIDTH(CW), .NUM_IPIN(NP)) bus1 ();

    cby_cfg_shadow_param u_dut (
        .prog_clk (clk),
        .pReset   (rst),
        .bus      (bus0)
    );

    cby_cfg_shadow_param #(.EXPECT_BITS(48)) u_dut48 (
        .prog_clk (clk),
        .pReset   (rst),
        .bus      (bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [0:0] exp_q[$];

    int tap_tbl [NP][TAPS] = '{'{0, 5, 10}, '{0, 1, 6}, '{1, 2, 7}, '{2, 3, 8},
                               '{3, 4, 9}, '{4, 5, 10}, '{0, 5, 6}, '{1, 6, 7}};

    // ---------------- reference model ----------------
    bit mdl_sr[$];
    bit mdl_ar[TOTAL];
    int mdl_cnt;
    bit mdl_valid;
    bit mdl_err;

    function automatic void mdl_reset();
        mdl_sr.delete();
        for (int k = 0; k < TOTAL; k++) mdl_sr.push_back(1'b0);
        for (int k = 0; k < TOTAL; k++) mdl_ar[k] = 1'b0;
        mdl_cnt   = 0;
        mdl_valid = 1'b0;
        mdl_err   = 1'b0;
    endfunction

    function automatic bit mdl_legal(input int exp_bits);
        for (int i = 0; i < NP; i++) begin
            int ones = 0;
            for (int k = 0; k < MS; k++) ones += int'(mdl_sr[i*MS + k]);
            if (ones > 1) return 1'b0;
        end
        return (exp_bits == 0) || (mdl_cnt == exp_bits);
    endfunction

    function automatic void mdl_clock(input bit en, input bit head, input bit load);
        if (load) begin
            if (mdl_legal(0)) begin
                for (int k = 0; k < TOTAL; k++) mdl_ar[k] = mdl_sr[k];
                mdl_valid = 1'b1;
            end else begin
                mdl_err = 1'b1;
            end
        end
        if (en) begin
            mdl_sr.push_front(head);
            void'(mdl_sr.pop_back());
        end
        if (load) mdl_cnt = en ? 1 : 0;
        else if (en && mdl_cnt < 65535) mdl_cnt++;
    endfunction

    function automatic logic [NP-1:0] mdl_ipin(input logic [CW-1:0] b, input logic [CW-1:0] t);
        logic [NP-1:0] r = '0;
        for (int i = 0; i < NP; i++) begin
            for (int k = 0; k < MS; k++) begin
                if (mdl_ar[i*MS + k]) begin
                    int trk = tap_tbl[i][k/2];
                    r[i] = r[i] | ((k % 2 == 1) ? t[trk] : b[trk]);
                end
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard / checks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        check("mdl_ipin",  64'(bus0.ipin_out),  64'(mdl_ipin(bus0.chany_bottom_in, bus0.chany_top_in)));
        check("mdl_valid", 64'(bus0.cfg_valid), 64'(mdl_valid));
        check("mdl_error", 64'(bus0.cfg_error), 64'(mdl_err));
        check("mdl_tail",  64'(bus0.ccff_tail), 64'(mdl_sr[TOTAL-1]));
        check("mdl_cnt",   64'(bus0.dbg_cnt),   64'(mdl_cnt));
        check("pass_up",   64'(bus0.chany_top_out),    64'(bus0.chany_bottom_in));
        check("pass_down", 64'(bus0.chany_bottom_out), 64'(bus0.chany_top_in));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit en, input bit head, input bit load);
        bus0.ccff_en   = en;
        bus0.ccff_head = head;
        bus0.cfg_load  = load;
        @(posedge clk);
        mdl_clock(en, head, load);
        @(negedge clk);
        bus0.ccff_en  = 1'b0;
        bus0.cfg_load = 1'b0;
        check_model();
    endtask

    task automatic step1(input bit en, input bit head, input bit load);
        bus1.ccff_en   = en;
        bus1.ccff_head = head;
        bus1.cfg_load  = load;
        @(posedge clk);
        @(negedge clk);
        bus1.ccff_en  = 1'b0;
        bus1.cfg_load = 1'b0;
    endtask

    task automatic shift_word(input logic [TOTAL-1:0] w);
        for (int k = TOTAL - 1; k >= 0; k--) step(1'b1, w[k], 1'b0);
    endtask

    task automatic set_chan(input logic [CW-1:0] b, input logic [CW-1:0] t);
        bus0.chany_bottom_in = b;
        bus0.chany_top_in    = t;
        #1;
    endtask

    function automatic logic [TOTAL-1:0] legal_word();
        logic [TOTAL-1:0] w = '0;
        for (int i = 0; i < NP; i++) begin
            int r = $urandom_range(0, MS);
            if (r < MS) w[i*MS + r] = 1'b1;
        end
        return w;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t vecs[8];
        logic [TOTAL-1:0] w;

        vecs[0] = '{48'h0,            11'h7FF, 11'h7FF, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{48'h8,            11'h000, 11'h020, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{48'h8,            11'h7FF, 11'h000, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{48'h40,           11'h001, 11'h000, 8'h02, 1'b1, 1'b0};
        vecs[4] = '{48'h8000_0000_0000, 11'h000, 11'h080, 8'h80, 1'b1, 1'b0};
        vecs[5] = '{48'h5000,         11'h000, 11'h080, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{48'h40_0000,      11'h100, 11'h000, 8'h08, 1'b1, 1'b1};
        vecs[7] = '{48'h0410_4104_1041, 11'h001, 11'h000, 8'h43, 1'b1, 1'b1};

        bus0.chany_bottom_in = '0; bus0.chany_top_in = '0;
        bus0.ccff_head = 1'b0; bus0.ccff_en = 1'b0; bus0.cfg_load = 1'b0;
        bus1.chany_bottom_in = '0; bus1.chany_top_in = '0;
        bus1.ccff_head = 1'b0; bus1.ccff_en = 1'b0; bus1.cfg_load = 1'b0;

        // T1: reset with random channel activity
        rst = 1'b1;
        mdl_reset();
        set_chan(CW'($urandom), CW'($urandom));
        @(negedge clk);
        check("t1_ipin",  64'(bus0.ipin_out),  64'h0);
        check("t1_valid", 64'(bus0.cfg_valid), 64'h0);
        check("t1_error", 64'(bus0.cfg_error), 64'h0);
        check("t1_tail",  64'(bus0.ccff_tail), 64'h0);
        check("t1_pass",  64'(bus0.chany_top_out), 64'(bus0.chany_bottom_in));
        rst = 1'b0;

        // T2: select pin0 bit3 (top of track 5); pins stay quiet while shifting
        for (int k = TOTAL - 1; k >= 0; k--) begin
            set_chan(CW'($urandom), CW'($urandom));
            step(1'b1, k == 3, 1'b0);
            check("t2_quiet", 64'(bus0.ipin_out), 64'h0);
        end
        step(1'b0, 1'b0, 1'b1);
        set_chan(11'h000, 11'h020);
        check("t2_follow_hi", 64'(bus0.ipin_out), 64'h01);
        set_chan(11'h7FF, 11'h7DF);
        check("t2_follow_lo", 64'(bus0.ipin_out), 64'h00);
        check("t2_valid", 64'(bus0.cfg_valid), 64'h1);

        // Table vectors (vector 5 is the two-hot pin2 rejection)
        for (int v = 0; v < 8; v++) begin
            shift_word(vecs[v].word);
            step(1'b0, 1'b0, 1'b1);
            set_chan(vecs[v].bot, vecs[v].top);
            check($sformatf("vec%0d_ipin", v),  64'(bus0.ipin_out),  64'(vecs[v].ipin));
            check($sformatf("vec%0d_valid", v), 64'(bus0.cfg_valid), 64'(vecs[v].valid));
            check($sformatf("vec%0d_error", v), 64'(bus0.cfg_error), 64'(vecs[v].err));
        end

        // T5: chain emits a pattern in order at ccff_tail
        for (int k = 0; k < TOTAL; k++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            exp_q.push_back(b);
            step(1'b1, b, 1'b0);
        end
        for (int k = 0; k < TOTAL; k++) begin
            check("t5_tail", 64'(bus0.ccff_tail), 64'(exp_q.pop_front()));
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end

        // T6b: reset pulse in the middle of a shift
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0);
        bus0.ccff_en = 1'b1; bus0.ccff_head = 1'b1;
        @(posedge clk);
        mdl_clock(1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        mdl_reset();
        #1;
        check("t6_rst_ipin",  64'(bus0.ipin_out),  64'h0);
        check("t6_rst_state", 64'(bus0.dbg_state), 64'h0);
        check("t6_rst_tail",  64'(bus0.ccff_tail), 64'h0);
        check("t6_rst_cnt",   64'(bus0.dbg_cnt),   64'h0);
        @(negedge clk);
        bus0.ccff_en = 1'b0;
        rst = 1'b0;
        check_model();

        // T6a: load and shift in the same cycle captures the pre-shift word
        shift_word(48'h1);
        step(1'b1, 1'b1, 1'b1);
        check("t6_cnt_one", 64'(bus0.dbg_cnt),   64'h1);
        check("t6_valid",   64'(bus0.cfg_valid), 64'h1);
        check("t6_error0",  64'(bus0.cfg_error), 64'h0);
        set_chan(11'h001, 11'h000);
        check("t6_ipin", 64'(bus0.ipin_out), 64'h01);
        step(1'b0, 1'b0, 1'b1);
        check("t6_shifted_rejected", 64'(bus0.cfg_error), 64'h1);
        check("t6_ipin_kept", 64'(bus0.ipin_out), 64'h01);

        // T4: bit-count check on the EXPECT_BITS=48 instance
        w = 48'h8;
        for (int k = TOTAL - 2; k >= 0; k--) step1(1'b1, w[k], 1'b0);
        step1(1'b0, 1'b0, 1'b1);
        check("t4_short_error", 64'(bus1.cfg_error), 64'h1);
        check("t4_short_valid", 64'(bus1.cfg_valid), 64'h0);
        for (int k = TOTAL - 1; k >= 0; k--) step1(1'b1, w[k], 1'b0);
        step1(1'b0, 1'b0, 1'b1);
        check("t4_full_valid", 64'(bus1.cfg_valid), 64'h1);
        check("t4_full_error", 64'(bus1.cfg_error), 64'h1);
        bus1.chany_top_in = 11'h020;
        #1;
        check("t4_ipin", 64'(bus1.ipin_out), 64'h01);

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                int n;
                n = $urandom_range(1, 8);
                for (int k = 0; k < n; k++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            end else if (op == 4) begin
                shift_word(legal_word());
            end else if (op <= 6) begin
                step(1'b0, 1'b0, 1'b1);
            end else if (op == 7) begin
                step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
            end else if (op == 8) begin
                set_chan(CW'($urandom), CW'($urandom));
                check_model();
            end else begin
                shift_word({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
